icache_direct: RTL



---
 rtl/mips_cache_pkg.sv | 40 ++++
 rtl/icache_line_store.sv | 54 +++++
 rtl/icache_direct.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mips_cache_pkg.sv
// Shared cache definitions: address-field widths, refill FSM states and
// address-split helpers used by the instruction cache.
package mips_cache_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned NUM_LINES      = 16;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned OFFSET_W       = 2;
    localparam int unsigned WORD_W         = $clog2(WORDS_PER_LINE);
    localparam int unsigned INDEX_W        = $clog2(NUM_LINES);
    localparam int unsigned TAG_W          = ADDR_W - OFFSET_W - WORD_W - INDEX_W;

    typedef enum logic {
        IDLE,
        REFILL
    } state_e;

    function automatic logic [ADDR_W-1:0] addr_word(input logic [ADDR_W-1:0] a,
                                                    input int unsigned word_w);
        return (a >> OFFSET_W) & ((ADDR_W'(1) << word_w) - ADDR_W'(1));
    endfunction

    function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] a,
                                                     input int unsigned word_w,
                                                     input int unsigned index_w);
        return (a >> (OFFSET_W + word_w)) & ((ADDR_W'(1) << index_w) - ADDR_W'(1));
    endfunction

    function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a,
                                                   input int unsigned word_w,
                                                   input int unsigned index_w);
        return a >> (OFFSET_W + word_w + index_w);
    endfunction

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a,
                                                    input int unsigned word_w);
        return a & ~((ADDR_W'(1) << (OFFSET_W + word_w)) - ADDR_W'(1));
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the direct-mapped cache: one combinational read
// port, one write port, and a global valid clear.
module icache_line_store #(
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned INDEX_W        = 4,
    parameter int unsigned WORD_W         = 2,
    parameter int unsigned TAG_W          = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic [INDEX_W-1:0] rd_index_i,
    input  logic [WORD_W-1:0]  rd_word_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [31:0]        rd_data_o,
    input  logic               wr_data_en_i,
    input  logic               wr_line_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [WORD_W-1:0]  wr_word_i,
    input  logic [31:0]        wr_data_i,
    input  logic [TAG_W-1:0]   wr_tag_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];

    // Clear has priority so a flush coinciding with a line completion wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (wr_line_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_data_en_i) begin
            data_q[wr_index_i][wr_word_i] <= wr_data_i;
        end
        if (wr_line_en_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i][rd_word_i];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped blocking instruction cache: combinational hit path from pc,
// whole-line refill over a beat-by-beat valid/ready memory handshake.
module icache_direct #(
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic [31:0]       instruction,
    output logic              hit,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    import mips_cache_pkg::*;

    localparam int unsigned WORD_BITS  = $clog2(WORDS_PER_LINE);
    localparam int unsigned INDEX_BITS = $clog2(NUM_LINES);
    localparam int unsigned TAG_BITS   = ADDR_W - OFFSET_W - WORD_BITS - INDEX_BITS;
    localparam int unsigned PKG_W      = mips_cache_pkg::ADDR_W;

    logic [PKG_W-1:0]      pc_w;
    logic [WORD_BITS-1:0]  pc_word;
    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [ADDR_W-1:0]     pc_base;

    assign pc_w     = PKG_W'(pc);
    assign pc_word  = WORD_BITS'(addr_word(pc_w, WORD_BITS));
    assign pc_index = INDEX_BITS'(addr_index(pc_w, WORD_BITS, INDEX_BITS));
    assign pc_tag   = TAG_BITS'(addr_tag(pc_w, WORD_BITS, INDEX_BITS));
    assign pc_base  = ADDR_W'(line_base(pc_w, WORD_BITS));

    state_e                state_q, state_d;
    logic [WORD_BITS-1:0]  beat_q, beat_d;
    logic [INDEX_BITS-1:0] index_q, index_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;

    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic                  lookup_hit;
    logic                  beat_accept;
    logic                  last_beat;
    logic                  wr_data_en;
    logic                  wr_line_en;

    assign lookup_hit  = rd_valid && (rd_tag == pc_tag);
    assign beat_accept = mem_req_q && mem_ready && !flush;
    assign last_beat   = (beat_q == WORD_BITS'(WORDS_PER_LINE - 1));

    icache_line_store #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .INDEX_W        (INDEX_BITS),
        .WORD_W         (WORD_BITS),
        .TAG_W          (TAG_BITS)
    ) u_store (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (flush),
        .rd_index_i   (pc_index),
        .rd_word_i    (pc_word),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_data_o    (rd_data),
        .wr_data_en_i (wr_data_en),
        .wr_line_en_i (wr_line_en),
        .wr_index_i   (index_q),
        .wr_word_i    (beat_q),
        .wr_data_i    (mem_rdata),
        .wr_tag_i     (tag_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            index_q    <= '0;
            tag_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            index_q    <= index_d;
            tag_q      <= tag_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        index_d    = index_q;
        tag_d      = tag_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (!flush && !lookup_hit) begin
                    state_d    = REFILL;
                    index_d    = pc_index;
                    tag_d      = pc_tag;
                    beat_d     = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_base;
                end
            end
            REFILL: begin
                // A flush abandons the partially written line; it is never marked valid.
                if (flush || (beat_accept && last_beat)) begin
                    state_d   = IDLE;
                    beat_d    = '0;
                    mem_req_d = 1'b0;
                end else if (beat_accept) begin
                    beat_d     = beat_q + WORD_BITS'(1);
                    mem_addr_d = mem_addr_q + ADDR_W'(4);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hit        = 1'b0;
        wr_data_en = 1'b0;
        wr_line_en = 1'b0;
        case (state_q)
            IDLE:    hit = lookup_hit && !flush;
            REFILL: begin
                wr_data_en = beat_accept;
                wr_line_en = beat_accept && last_beat;
            end
            default: hit = 1'b0;
        endcase
        instruction = hit ? rd_data : '0;
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule
